// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Forwarding and hazard controller for the in-order pipeline. It tracks the
// destination-register state of EX and FWD_DEPTH downstream stages
// (S1 = MEM, S2 = WB, ...). From that state it produces:
//   - per-operand forwarding selects for the EX operand muxes,
//   - load-use stalls sized to the configured load latency,
//   - bubble insertion into EX,
//   - flush handling, deferred across busy freezes.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   id_valid            ID holds a real instruction
//   id_rs1, id_rs2      ID source registers
//   id_uses_rs          bit0 = rs1 read, bit1 = rs2 read
//   id_rd, id_wen       ID destination register and write enable
//   id_is_load          ID instruction is a load
//   flush               redirect resolved in stage 1
//   busy                multi-cycle unit in EX, freezes the tracked pipeline
//   stall_id            hold PC and IF/ID
//   bubble_ex           EX entry written this edge is a bubble
//   fwd_sel_a/b         EX operand source: 0 = regfile, k = stage k result
//   perf_stall_cnt      (HAZARD_PERF_EN only) saturating stall-cycle count
//   perf_flush_cnt      (HAZARD_PERF_EN only) saturating applied-flush count
//
// Optional feature macro: HAZARD_PERF_EN adds the two performance counters.
//
// FSM states:
//   state         | meaning
//   --------------+-----------------------------------------------------------
//   ST_RUN        | normal operation, no flush outstanding
//   ST_FREEZE     | last edge was frozen by busy, no flush outstanding
//   ST_FLUSH_PEND | a flush arrived during busy; applied on first edge with
//                 | busy = 0, then back to ST_RUN
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [1:0]            id_uses_rs,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wen,
    input  logic                  id_is_load,
    input  logic                  flush,
    input  logic                  busy,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic [SEL_W-1:0]      fwd_sel_a,
    output logic [SEL_W-1:0]      fwd_sel_b
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);

    // Index 0 is EX, index k (1..FWD_DEPTH) is stage Sk.
    localparam int NST = FWD_DEPTH + 1;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FREEZE     = 2'd1,
        ST_FLUSH_PEND = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [NST-1:0]                 vld_q, vld_d;
    logic [NST-1:0]                 wen_q, wen_d;
    logic [NST-1:0]                 ld_q, ld_d;
    logic [NST-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
    logic [REG_ADDR_W-1:0]          ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0]          ex_rs2_q, ex_rs2_d;
    logic [1:0]                     ex_uses_q, ex_uses_d;

    logic flush_pend;
    logic apply_flush;
    logic ld_hit_rs1;
    logic ld_hit_rs2;
    logic ld_haz;

    assign flush_pend  = (state_q == ST_FLUSH_PEND);
    assign apply_flush = ~busy & (flush | flush_pend);

    // Load-use detection: a load still in EX or S1..S(LOAD_LAT-1) cannot
    // supply its data to the instruction that would enter EX next.
    always_comb begin
        ld_hit_rs1 = 1'b0;
        ld_hit_rs2 = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (vld_q[k] && wen_q[k] && ld_q[k] && (rd_q[k] != '0)) begin
                if (rd_q[k] == id_rs1) ld_hit_rs1 = 1'b1;
                if (rd_q[k] == id_rs2) ld_hit_rs2 = 1'b1;
            end
        end
        ld_haz = id_valid & ((id_uses_rs[0] & ld_hit_rs1) |
                             (id_uses_rs[1] & ld_hit_rs2));
    end

    // Outputs are forced low while reset is held, even if busy is asserted.
    assign stall_id  = rst & (busy | ld_haz);
    assign bubble_ex = rst & ~busy & (flush | flush_pend | ld_haz);

    // Forwarding select: walk from the oldest stage toward S1 so the youngest
    // matching producer wins. Loads not yet past LOAD_LAT carry no data.
    always_comb begin
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (vld_q[k] && wen_q[k] && (rd_q[k] != '0) &&
                !(ld_q[k] && (k <= LOAD_LAT))) begin
                if (rd_q[k] == ex_rs1_q) fwd_sel_a = SEL_W'(k);
                if (rd_q[k] == ex_rs2_q) fwd_sel_b = SEL_W'(k);
            end
        end
        if (!vld_q[0] || !ex_uses_q[0]) fwd_sel_a = '0;
        if (!vld_q[0] || !ex_uses_q[1]) fwd_sel_b = '0;
    end

    // Next-state of the tracking chain and FSM.
    always_comb begin
        state_d   = state_q;
        vld_d     = vld_q;
        wen_d     = wen_q;
        ld_d      = ld_q;
        rd_d      = rd_q;
        ex_rs1_d  = ex_rs1_q;
        ex_rs2_d  = ex_rs2_q;
        ex_uses_d = ex_uses_q;

        if (busy) begin
            // Everything holds; remember a flush for the first unfrozen edge.
            state_d = (flush || flush_pend) ? ST_FLUSH_PEND : ST_FREEZE;
        end else begin
            state_d = ST_RUN;

            // S2 and beyond shift in every unfrozen edge.
            for (int k = NST - 1; k >= 2; k--) begin
                vld_d[k] = vld_q[k-1];
                wen_d[k] = wen_q[k-1];
                ld_d[k]  = ld_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end

            if (apply_flush) begin
                // The redirecting instruction's younger neighbour in EX and
                // the instruction in ID are squashed; S1 becomes empty.
                vld_d[1] = 1'b0;
                wen_d[1] = 1'b0;
                ld_d[1]  = 1'b0;
                rd_d[1]  = '0;
            end else begin
                vld_d[1] = vld_q[0];
                wen_d[1] = wen_q[0];
                ld_d[1]  = ld_q[0];
                rd_d[1]  = rd_q[0];
            end

            if (apply_flush || ld_haz) begin
                vld_d[0]  = 1'b0;
                wen_d[0]  = 1'b0;
                ld_d[0]   = 1'b0;
                rd_d[0]   = '0;
                ex_rs1_d  = '0;
                ex_rs2_d  = '0;
                ex_uses_d = '0;
            end else begin
                vld_d[0]  = id_valid;
                wen_d[0]  = id_wen;
                ld_d[0]   = id_is_load;
                rd_d[0]   = id_rd;
                ex_rs1_d  = id_rs1;
                ex_rs2_d  = id_rs2;
                ex_uses_d = id_uses_rs;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            vld_q     <= '0;
            wen_q     <= '0;
            ld_q      <= '0;
            rd_q      <= '0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            ex_uses_q <= '0;
        end else begin
            state_q   <= state_d;
            vld_q     <= vld_d;
            wen_q     <= wen_d;
            ld_q      <= ld_d;
            rd_q      <= rd_d;
            ex_rs1_q  <= ex_rs1_d;
            ex_rs2_q  <= ex_rs2_d;
            ex_uses_q <= ex_uses_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Saturating counters; a latched flush counts only when it is applied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_id && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (apply_flush && (perf_flush_q != 32'hFFFF_FFFF)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int NI = 2;   // instance 0: defaults, instance 1: depth 4 / lat 3
    localparam int AW = 5;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          wen;
        logic          ld;
    } ent_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [1:0]    uses;
        logic [AW-1:0] rd;
        logic          wen;
        logic          ld;
    } instr_t;

    typedef struct packed {
        logic [NI-1:0]        stall;
        logic [NI-1:0]        bubble;
        logic [NI-1:0][2:0]   sa;
        logic [NI-1:0][2:0]   sb;
        logic [NI-1:0][31:0]  pst;
        logic [NI-1:0][31:0]  pfl;
    } exp_t;

    logic clk;
    logic rst;
    logic busy;
    logic flush;

    logic          id_valid [NI];
    logic [AW-1:0] id_rs1   [NI];
    logic [AW-1:0] id_rs2   [NI];
    logic [1:0]    id_uses  [NI];
    logic [AW-1:0] id_rd    [NI];
    logic          id_wen   [NI];
    logic          id_ld    [NI];
    logic          stall    [NI];
    logic          bubble   [NI];
    logic [1:0]    sa0, sb0;
    logic [2:0]    sa1, sb1;
`ifdef HAZARD_PERF_EN
    logic [31:0]   pst [NI];
    logic [31:0]   pfl [NI];
`endif

    pipe_hazard_ctrl u_dut0 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid[0]), .id_rs1(id_rs1[0]), .id_rs2(id_rs2[0]),
        .id_uses_rs(id_uses[0]), .id_rd(id_rd[0]), .id_wen(id_wen[0]),
        .id_is_load(id_ld[0]), .flush(flush), .busy(busy),
        .stall_id(stall[0]), .bubble_ex(bubble[0]),
        .fwd_sel_a(sa0), .fwd_sel_b(sb0)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(pst[0]), .perf_flush_cnt(pfl[0])
`endif
    );

    pipe_hazard_ctrl #(.FWD_DEPTH(4), .LOAD_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid[1]), .id_rs1(id_rs1[1]), .id_rs2(id_rs2[1]),
        .id_uses_rs(id_uses[1]), .id_rd(id_rd[1]), .id_wen(id_wen[1]),
        .id_is_load(id_ld[1]), .flush(flush), .busy(busy),
        .stall_id(stall[1]), .bubble_ex(bubble[1]),
        .fwd_sel_a(sa1), .fwd_sel_b(sb1)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(pst[1]), .perf_flush_cnt(pfl[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    ent_t          st      [NI][5];   // [0] = EX, [k] = Sk
    logic [AW-1:0] ex_rs1_m[NI];
    logic [AW-1:0] ex_rs2_m[NI];
    logic [1:0]    ex_use_m[NI];
    bit            pend_m  [NI];
    logic [31:0]   pst_m   [NI];
    logic [31:0]   pfl_m   [NI];

    instr_t cur  [NI];
    bit     hold [NI];
    int     ip   [NI];
    instr_t prog [$];
    exp_t   sbq  [$];

    int errors = 0;
    int checks = 0;

    function automatic int depth_of(int m); return (m == 0) ? 2 : 4; endfunction
    function automatic int lat_of(int m);   return (m == 0) ? 1 : 3; endfunction

    function automatic bit writes_reg(ent_t e, logic [AW-1:0] r);
        return e.v && e.wen && (e.rd != 0) && (e.rd == r);
    endfunction

    // A used source whose producer is a load that has not reached S(LOAD_LAT).
    function automatic bit m_ldhaz(int m, instr_t i);
        bit h = 0;
        if (!i.valid) return 0;
        for (int k = 0; k < lat_of(m); k++) begin
            if (st[m][k].ld &&
                ((i.uses[0] && writes_reg(st[m][k], i.rs1)) ||
                 (i.uses[1] && writes_reg(st[m][k], i.rs2))))
                h = 1;
        end
        return h;
    endfunction

    // Youngest (smallest k) forwardable producer, else regfile.
    function automatic int m_sel(int m, bit used, logic [AW-1:0] rs);
        if (!used || !st[m][0].v || rs == 0) return 0;
        for (int k = 1; k <= depth_of(m); k++) begin
            if (writes_reg(st[m][k], rs) && !(st[m][k].ld && k <= lat_of(m)))
                return k;
        end
        return 0;
    endfunction

    task automatic m_clear(int m);
        for (int k = 0; k < 5; k++) st[m][k] = '0;
        ex_rs1_m[m] = '0;
        ex_rs2_m[m] = '0;
        ex_use_m[m] = '0;
        pend_m[m]   = 0;
        pst_m[m]    = '0;
        pfl_m[m]    = '0;
    endtask

    task automatic m_edge(int m, instr_t i, bit stall_now);
        bit hz;
        hz = m_ldhaz(m, i);
        if (!rst) begin
            m_clear(m);
            return;
        end
        if (stall_now && pst_m[m] != 32'hFFFF_FFFF) pst_m[m] = pst_m[m] + 1;
        if (busy) begin
            if (flush) pend_m[m] = 1;
            return;
        end
        if (flush || pend_m[m]) begin
            for (int k = depth_of(m); k >= 2; k--) st[m][k] = st[m][k-1];
            st[m][1] = '0;
            st[m][0] = '0;
            ex_rs1_m[m] = '0; ex_rs2_m[m] = '0; ex_use_m[m] = '0;
            pend_m[m] = 0;
            if (pfl_m[m] != 32'hFFFF_FFFF) pfl_m[m] = pfl_m[m] + 1;
        end else begin
            for (int k = depth_of(m); k >= 1; k--) st[m][k] = st[m][k-1];
            if (hz) begin
                st[m][0] = '0;
                ex_rs1_m[m] = '0; ex_rs2_m[m] = '0; ex_use_m[m] = '0;
            end else begin
                st[m][0] = '{v: i.valid, rd: i.rd, wen: i.wen, ld: i.ld};
                ex_rs1_m[m] = i.rs1; ex_rs2_m[m] = i.rs2; ex_use_m[m] = i.uses;
            end
        end
    endtask

    function automatic instr_t mk(bit v, int rs1, int rs2, int uses, int rd, bit wen, bit ld);
        instr_t i;
        i.valid = v; i.rs1 = AW'(rs1); i.rs2 = AW'(rs2); i.uses = 2'(uses);
        i.rd = AW'(rd); i.wen = wen; i.ld = ld;
        return i;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        i.valid = ($urandom_range(0, 4) != 0);
        i.rs1   = AW'($urandom_range(0, 3));
        i.rs2   = AW'($urandom_range(0, 3));
        i.uses  = 2'($urandom_range(0, 3));
        i.rd    = AW'($urandom_range(0, 3));
        i.wen   = ($urandom_range(0, 4) != 0);
        i.ld    = ($urandom_range(0, 2) == 0);
        return i;
    endfunction

    // ---------------- stimulus ----------------
    task automatic do_cycle();
        exp_t e;
        bit hz;
        e = '0;
        for (int m = 0; m < NI; m++) begin
            if (!rst) m_clear(m);
            id_valid[m] = cur[m].valid; id_rs1[m] = cur[m].rs1; id_rs2[m] = cur[m].rs2;
            id_uses[m]  = cur[m].uses;  id_rd[m]  = cur[m].rd;  id_wen[m] = cur[m].wen;
            id_ld[m]    = cur[m].ld;
            hz = m_ldhaz(m, cur[m]);
            e.stall[m]  = rst && (busy || hz);
            e.bubble[m] = rst && !busy && (flush || pend_m[m] || hz);
            e.sa[m]     = 3'(m_sel(m, ex_use_m[m][0], ex_rs1_m[m]));
            e.sb[m]     = 3'(m_sel(m, ex_use_m[m][1], ex_rs2_m[m]));
            e.pst[m]    = pst_m[m];
            e.pfl[m]    = pfl_m[m];
        end
        sbq.push_back(e);
        @(posedge clk);
        for (int m = 0; m < NI; m++) begin
            m_edge(m, cur[m], e.stall[m]);
            hold[m] = e.stall[m];
        end
        #1;
    endtask

    // Runs a directed program (rnd = 0) or random traffic (rnd = 1).
    // The program feeds each instance separately so each honours its own stall.
    task automatic run(input int ncyc, input int b_from, input int b_len,
                       input int f_at, input int r_at, input bit rnd);
        for (int m = 0; m < NI; m++) ip[m] = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (rnd) begin
                busy  = ($urandom_range(0, 7) == 0);
                flush = ($urandom_range(0, 9) == 0);
                rst   = ($urandom_range(0, 99) != 0);
            end else begin
                busy  = (c >= b_from) && (c < b_from + b_len);
                flush = (c == f_at);
                rst   = (c != r_at);
            end
            for (int m = 0; m < NI; m++) begin
                if (!hold[m]) begin
                    if (rnd) cur[m] = rnd_instr();
                    else begin
                        cur[m] = (ip[m] < prog.size()) ? prog[ip[m]] : '0;
                        ip[m]++;
                    end
                end
            end
            do_cycle();
        end
    endtask

    // ---------------- monitor ----------------
    task automatic chk(int m, string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, m, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk(0, "stall_id",  32'(stall[0]),  32'(e.stall[0]));
                chk(0, "bubble_ex", 32'(bubble[0]), 32'(e.bubble[0]));
                chk(0, "fwd_sel_a", 32'(sa0),       32'(e.sa[0]));
                chk(0, "fwd_sel_b", 32'(sb0),       32'(e.sb[0]));
                chk(1, "stall_id",  32'(stall[1]),  32'(e.stall[1]));
                chk(1, "bubble_ex", 32'(bubble[1]), 32'(e.bubble[1]));
                chk(1, "fwd_sel_a", 32'(sa1),       32'(e.sa[1]));
                chk(1, "fwd_sel_b", 32'(sb1),       32'(e.sb[1]));
`ifdef HAZARD_PERF_EN
                for (int m = 0; m < NI; m++) begin
                    chk(m, "perf_stall_cnt", pst[m], e.pst[m]);
                    chk(m, "perf_flush_cnt", pfl[m], e.pfl[m]);
                end
`endif
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0; busy = 1'b0; flush = 1'b0;
        for (int m = 0; m < NI; m++) begin
            cur[m] = '0; hold[m] = 0; ip[m] = 0;
            m_clear(m);
        end
        @(posedge clk); #1;
        repeat (3) do_cycle();
        rst = 1'b1;

        // producer then back-to-back consumers of x5
        prog = {};
        prog.push_back(mk(1, 0, 0, 1, 5, 1, 0));
        prog.push_back(mk(1, 5, 5, 3, 6, 1, 0));
        prog.push_back(mk(1, 5, 5, 3, 7, 1, 0));
        run(8, -1, 0, -1, -1, 0);

        // load-use, dependent consumer immediately behind
        prog = {};
        prog.push_back(mk(1, 1, 0, 1, 7, 1, 1));
        prog.push_back(mk(1, 7, 0, 3, 8, 1, 0));
        run(10, -1, 0, -1, -1, 0);

        // load to x9 with immediate consumer, then with consumer trailing by 2
        prog = {};
        prog.push_back(mk(1, 1, 0, 1, 9, 1, 1));
        prog.push_back(mk(1, 9, 9, 3, 10, 1, 0));
        prog.push_back(mk(1, 1, 0, 1, 9, 1, 1));
        prog.push_back(mk(1, 1, 2, 3, 12, 1, 0));
        prog.push_back(mk(1, 9, 0, 1, 11, 1, 0));
        run(18, -1, 0, -1, -1, 0);

        // x0 writes are never forwarded; two producers of x3 -> youngest wins
        prog = {};
        prog.push_back(mk(1, 1, 0, 1, 0, 1, 0));
        prog.push_back(mk(1, 0, 0, 3, 4, 1, 0));
        prog.push_back(mk(1, 1, 0, 1, 3, 1, 0));
        prog.push_back(mk(1, 2, 0, 1, 3, 1, 0));
        prog.push_back(mk(1, 3, 3, 3, 5, 1, 0));
        run(10, -1, 0, -1, -1, 0);

        // busy for 3 cycles with a flush in the second one
        prog = {};
        prog.push_back(mk(1, 0, 0, 1, 5, 1, 0));
        prog.push_back(mk(1, 5, 0, 1, 6, 1, 0));
        prog.push_back(mk(1, 6, 5, 3, 7, 1, 0));
        prog.push_back(mk(1, 7, 0, 1, 8, 1, 0));
        run(12, 2, 3, 3, -1, 0);

        // reset asserted in the middle of a load-use stall
        prog = {};
        prog.push_back(mk(1, 1, 0, 1, 7, 1, 1));
        prog.push_back(mk(1, 7, 0, 1, 8, 1, 0));
        prog.push_back(mk(1, 8, 0, 1, 9, 1, 0));
        prog.push_back(mk(1, 9, 9, 3, 10, 1, 0));
        run(10, -1, 0, -1, 2, 0);

        // random traffic over a small register set to provoke hazards
        run(3000, -1, 0, -1, -1, 1);

        busy = 1'b0; flush = 1'b0; rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
